// File: rtl/lsu_pkg.sv
// Package for the MEM-stage load/store unit.
// Holds the FSM state type, the RV32I funct3 size/sign encodings and
// helpers that classify an access as legal and as aligned.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Halves must sit on an even address, words on a multiple of four.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Stores have no unsigned forms, so 1xx is illegal for them.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    if (we) return funct3 inside {F3_B, F3_H, F3_W};
    return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-bus interface between the load/store unit (master) and memory (slave).
// Signals:
//   bus_req    master->slave  request, held until bus_gnt
//   bus_we     master->slave  1 = write
//   bus_addr   master->slave  word address (low two bits zero)
//   bus_be     master->slave  byte enables
//   bus_wdata  master->slave  lane-replicated store data
//   bus_gnt    slave->master  request accepted this cycle
//   bus_rvalid slave->master  read data valid
//   bus_rdata  slave->master  read word
// Handshake: a request transfers on a rising edge where bus_req and bus_gnt
// are both 1; until then the master keeps bus_req and every request field
// stable. For reads, bus_rvalid qualifies bus_rdata for exactly one cycle and
// arrives no earlier than the cycle after the grant; the master has no way to
// refuse it.
interface lsu_bus_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the load/store unit.
// Ports:
//   funct3_i     size/sign field
//   addr_lo_i    byte offset within the word
//   wdata_i      unaligned store data (rs2)
//   rdata_i      read word from the bus
//   be_o         byte enables for the access
//   wdata_o      store data replicated across lanes
//   load_data_o  selected byte/half/word, sign- or zero-extended
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    // funct3[1:0] is the size regardless of the unsigned bit.
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      2'b10:   be_o = 4'b1111;
      default: be_o = 4'b0000;
    endcase
  end

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data_o = {24'd0, byte_sel};
      F3_HU:   load_data_o = {16'd0, half_sel};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit. Accepts the MEM-stage access, drives one bus
// transaction through lsu_bus_if, stalls the pipeline until it completes and
// returns extended load data. Illegal or misaligned accesses never reach the
// bus; they pulse err_o in the cycle they are presented.
// Ports:
//   clk_i, reset_i        clock, asynchronous active-low reset
//   req_valid_i/we_i      MEM stage holds an access / access is a store
//   req_funct3_i          size/sign field
//   req_addr_i/wdata_i    byte address, unaligned store data
//   stall_o               freeze IF..MEM
//   load_valid_o          load_data_o valid this cycle
//   load_data_o           extended load result
//   err_o                 one-cycle error pulse (illegal, misaligned, timeout)
//   bus                   data-bus master
//   state_o               current FSM state, for observation
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  input  logic             req_we_i,
  input  logic [2:0]       req_funct3_i,
  input  logic [31:0]      req_addr_i,
  input  logic [31:0]      req_wdata_i,
  output logic             stall_o,
  output logic             load_valid_o,
  output logic [31:0]      load_data_o,
  output logic             err_o,
  lsu_bus_if.master        bus,
  output lsu_state_t       state_o
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [7:0]  cnt_q;
  logic        to_err_q;
  logic [31:0] load_data_q;

  logic        idle_req;
  logic        access_ok;
  logic [2:0]  al_f3;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;

  // Gating with reset_i keeps every output low while reset is held, even
  // though the pipeline may still present a request.
  assign idle_req  = (state_q == IDLE) && req_valid_i && reset_i;
  assign access_ok = is_legal(req_we_i, req_funct3_i) && !is_misaligned(req_funct3_i, req_addr_i[1:0]);

  // In IDLE the aligner looks at the incoming request so be/wdata can be
  // latched; afterwards it looks at the latched access for load extraction.
  assign al_f3      = (state_q == IDLE) ? req_funct3_i    : f3_q;
  assign al_addr_lo = (state_q == IDLE) ? req_addr_i[1:0] : addr_q[1:0];

  lsu_align u_align (
    .funct3_i    (al_f3),
    .addr_lo_i   (al_addr_lo),
    .wdata_i     (req_wdata_i),
    .rdata_i     (bus.bus_rdata),
    .be_o        (al_be),
    .wdata_o     (al_wdata),
    .load_data_o (al_load)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= 32'd0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
      cnt_q       <= 8'd0;
      to_err_q    <= 1'b0;
      load_data_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i && access_ok) begin
            we_q     <= req_we_i;
            f3_q     <= req_funct3_i;
            addr_q   <= req_addr_i;
            be_q     <= al_be;
            wdata_q  <= al_wdata;
            cnt_q    <= 8'd0;
            to_err_q <= 1'b0;
            state_q  <= REQ;
          end
        end
        REQ, WAIT_R: begin
          cnt_q <= cnt_q + 8'd1;
          // A bus response in the last allowed cycle still wins over the abort.
          if (state_q == REQ && bus.bus_gnt) begin
            state_q <= we_q ? DONE : WAIT_R;
          end else if (state_q == WAIT_R && bus.bus_rvalid) begin
            load_data_q <= al_load;
            state_q     <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            to_err_q <= 1'b1;
            if (!we_q) load_data_q <= 32'd0;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall_o      = (idle_req && access_ok) || (state_q == REQ) || (state_q == WAIT_R);
    err_o        = (idle_req && !access_ok) || ((state_q == DONE) && to_err_q);
    load_valid_o = (idle_req && !access_ok && !req_we_i) || ((state_q == DONE) && !we_q);
    load_data_o  = (idle_req && !access_ok) ? 32'd0 : load_data_q;
  end

  assign bus.bus_req   = (state_q == REQ);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = {addr_q[31:2], 2'b00};
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        stall, load_valid, err;
  logic [31:0] load_data;
  lsu_state_t  state;

  lsu_bus_if bus_if ();

  load_store_unit dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .req_valid_i  (req_valid),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .stall_o      (stall),
    .load_valid_o (load_valid),
    .load_data_o  (load_data),
    .err_o        (err),
    .bus          (bus_if.master),
    .state_o      (state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Presents one access and plays the memory side. gnt_wait = number of REQ
  // cycles before the grant (-1 = never). Read data arrives the cycle after
  // the grant. Returns per-access observations.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input int gnt_wait,
                           output int stall_n, output int err_n, output int lv_n, output int req_n,
                           output logic [3:0] be_seen, output logic [31:0] wd_seen,
                           output logic [31:0] addr_seen);
    logic gnt_prev;
    logic done;
    stall_n = 0; err_n = 0; lv_n = 0; req_n = 0;
    be_seen = 4'd0; wd_seen = 32'd0; addr_seen = 32'd0;
    gnt_prev = 1'b0; done = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      if (stall) stall_n++;
      if (err) err_n++;
      if (load_valid) begin
        lv_n++;
        if (exp_q.size() == 0) check_eq("unexpected_load_valid", 32'd1, 32'd0);
        else check_eq("load_data", load_data, exp_q.pop_front());
      end
      bus_if.bus_rvalid = 1'b0;
      if (gnt_prev && !we) begin
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = rdata;
      end
      gnt_prev = 1'b0;
      bus_if.bus_gnt = 1'b0;
      if (bus_if.bus_req) begin
        req_n++;
        be_seen = bus_if.bus_be; wd_seen = bus_if.bus_wdata; addr_seen = bus_if.bus_addr;
        if (gnt_wait >= 0 && req_n > gnt_wait) begin
          bus_if.bus_gnt = 1'b1;
          gnt_prev = 1'b1;
        end
      end
      if (!stall) done = 1'b1;
    end
    if (!done) check_eq("access_cycle_bound", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0;
  endtask

  int s_n, e_n, l_n, r_n;
  logic [3:0]  be_s;
  logic [31:0] wd_s, ad_s;

  initial begin
    #1_000_000;
    $display("FAIL global_watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_state", 32'(state), 32'(IDLE));
    check_eq("rst_outs", {27'd0, stall, err, load_valid, bus_if.bus_req, bus_if.bus_we}, 32'd0);
    check_eq("rst_load_data", load_data, 32'd0);
    check_eq("rst_bus_be", 32'(bus_if.bus_be), 32'd0);
    reset_i = 1'b1;

    // SW 0x100, grant in first REQ cycle
    do_access(1'b1, F3_W, 32'h100, 32'hDEADBEEF, 32'd0, 0, s_n, e_n, l_n, r_n, be_s, wd_s, ad_s);
    check_eq("sw_stall", s_n, 2);
    check_eq("sw_be", 32'(be_s), 32'hF);
    check_eq("sw_addr", ad_s, 32'h100);
    check_eq("sw_wdata", wd_s, 32'hDEADBEEF);
    check_eq("sw_err", e_n, 0);
    check_eq("sw_lv", l_n, 0);
    check_eq("sw_req_cycles", r_n, 1);

    // SB 0x103
    do_access(1'b1, F3_B, 32'h103, 32'h000000A5, 32'd0, 0, s_n, e_n, l_n, r_n, be_s, wd_s, ad_s);
    check_eq("sb_be", 32'(be_s), 32'h8);
    check_eq("sb_wdata", wd_s, 32'hA5A5A5A5);
    check_eq("sb_addr", ad_s, 32'h100);

    // SH 0x102, grant after 3 waiting REQ cycles
    do_access(1'b1, F3_H, 32'h102, 32'h1234BEEF, 32'd0, 3, s_n, e_n, l_n, r_n, be_s, wd_s, ad_s);
    check_eq("sh_be", 32'(be_s), 32'hC);
    check_eq("sh_wdata", wd_s, 32'hBEEFBEEF);
    check_eq("sh_stall", s_n, 5);
    check_eq("sh_req_cycles", r_n, 4);

    // LB 0x102
    exp_q.push_back(32'hFFFFFF80);
    do_access(1'b0, F3_B, 32'h102, 32'd0, 32'h12805634, 0, s_n, e_n, l_n, r_n, be_s, wd_s, ad_s);
    check_eq("lb_stall", s_n, 3);
    check_eq("lb_be", 32'(be_s), 32'h4);
    check_eq("lb_lv", l_n, 1);
    check_eq("lb_err", e_n, 0);
    check_eq("lb_hold_after_done", load_data, 32'hFFFFFF80);

    // LBU 0x102
    exp_q.push_back(32'h00000080);
    do_access(1'b0, F3_BU, 32'h102, 32'd0, 32'h12805634, 0, s_n, e_n, l_n, r_n, be_s, wd_s, ad_s);
    check_eq("lbu_lv", l_n, 1);

    // LH / LHU upper half, LW
    exp_q.push_back(32'hFFFF8001);
    do_access(1'b0, F3_H, 32'h102, 32'd0, 32'h80011234, 0, s_n, e_n, l_n, r_n, be_s, wd_s, ad_s);
    check_eq("lh_be", 32'(be_s), 32'hC);
    exp_q.push_back(32'h00008001);
    do_access(1'b0, F3_HU, 32'h102, 32'd0, 32'h80011234, 1, s_n, e_n, l_n, r_n, be_s, wd_s, ad_s);
    check_eq("lhu_stall", s_n, 4);
    exp_q.push_back(32'h13579BDF);
    do_access(1'b0, F3_W, 32'h204, 32'd0, 32'h13579BDF, 0, s_n, e_n, l_n, r_n, be_s, wd_s, ad_s);
    check_eq("lw_addr", ad_s, 32'h204);

    // Misaligned LH: error, zero load, no bus, no stall
    exp_q.push_back(32'd0);
    do_access(1'b0, F3_H, 32'h101, 32'd0, 32'hFFFFFFFF, 0, s_n, e_n, l_n, r_n, be_s, wd_s, ad_s);
    check_eq("mis_err", e_n, 1);
    check_eq("mis_lv", l_n, 1);
    check_eq("mis_req", r_n, 0);
    check_eq("mis_stall", s_n, 0);

    // Illegal store funct3 100: error, no load result, no bus
    do_access(1'b1, 3'b100, 32'h100, 32'h11111111, 32'd0, 0, s_n, e_n, l_n, r_n, be_s, wd_s, ad_s);
    check_eq("ill_st_err", e_n, 1);
    check_eq("ill_st_lv", l_n, 0);
    check_eq("ill_st_req", r_n, 0);

    // LW timeout, grant never comes
    exp_q.push_back(32'd0);
    do_access(1'b0, F3_W, 32'h300, 32'd0, 32'd0, -1, s_n, e_n, l_n, r_n, be_s, wd_s, ad_s);
    check_eq("to_err", e_n, 1);
    check_eq("to_lv", l_n, 1);
    check_eq("to_req_cycles", r_n, 255);
    check_eq("to_stall", s_n, 256);
    check_eq("exp_q_empty", exp_q.size(), 0);

    // Reset in the middle of REQ
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h400;
    @(negedge clk);
    check_eq("mid_idle_stall", 32'(stall), 32'd1);
    @(negedge clk);
    check_eq("mid_in_req", 32'(bus_if.bus_req), 32'd1);
    #1 reset_i = 1'b0;
    #1;
    check_eq("mid_rst_req", 32'(bus_if.bus_req), 32'd0);
    check_eq("mid_rst_stall", 32'(stall), 32'd0);
    check_eq("mid_rst_state", 32'(state), 32'(IDLE));
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset_i = 1'b1;
    @(negedge clk);
    bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("late_rvalid_lv", 32'(load_valid), 32'd0);
      check_eq("late_rvalid_data", load_data, 32'd0);
      check_eq("late_rvalid_state", 32'(state), 32'(IDLE));
    end
    bus_if.bus_rvalid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
